note_sequencer: RTL and testbench

//  Step sequencer that drives the oscillator/envelope chain: per step it emits a phase

---
 rtl/note_sequencer_pkg.sv | 17 +
 rtl/note_sequencer_if.sv | 24 ++
 rtl/note_sequencer_step_ram.sv | 16 +
 rtl/note_sequencer.sv | 109 ++++++++++
 tb/tb_note_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg: step-word layout, sequencer states and a step-word builder
package note_sequencer_pkg;
  localparam int STEPS = 16;
  localparam int IDX_W = $clog2(STEPS);
  localparam int INC_WIDTH = 21;
  localparam int DUR_WIDTH = 12;
  localparam int WORD_W = INC_WIDTH + 2 * DUR_WIDTH;
  localparam int SL_LSB = 0;
  localparam int GL_LSB = DUR_WIDTH;
  localparam int INC_LSB = 2 * DUR_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  function automatic logic [WORD_W-1:0] step_word(input logic [INC_WIDTH-1:0] inc,
                                                  input logic [DUR_WIDTH-1:0] gl,
                                                  input logic [DUR_WIDTH-1:0] sl);
    return {inc, gl, sl};
  endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: CPU-side pattern/control port and oscillator/envelope outputs
interface note_sequencer_if;
  import note_sequencer_pkg::*;
  logic wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [IDX_W-1:0] num_steps;
  logic loop_en;
  logic start;
  logic stop;
  logic gate;
  logic [INC_WIDTH-1:0] increment;
  logic [IDX_W-1:0] step_idx;
  logic step_strobe;
  logic running;
  modport master (
    output wr_en, wr_addr, wr_data, num_steps, loop_en, start, stop,
    input gate, increment, step_idx, step_strobe, running
  );
  modport slave (
    input wr_en, wr_addr, wr_data, num_steps, loop_en, start, stop,
    output gate, increment, step_idx, step_strobe, running
  );
endinterface

// File: rtl/note_sequencer_step_ram.sv
// note_sequencer_step_ram: pattern store, one write port and one registered read port
module note_sequencer_step_ram import note_sequencer_pkg::*; (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem [STEPS];
  // read-before-write: a load colliding with a write sees the old entry
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: steps through the pattern RAM, timing gate and step length in sample ticks
module note_sequencer import note_sequencer_pkg::*; #(
  parameter int TICK_DIV = 32
) (
  input logic clk,
  input logic rst,
  input logic sample_clock,
  note_sequencer_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  state_t state;
  logic sc_q1, sc_q2, sample, tick, step_end, last;
  logic [PW-1:0] pre;
  logic [DUR_WIDTH-1:0] t, gate_len, step_len, rd_gl, rd_sl;
  logic [DUR_WIDTH:0] t_next, sl_eff;
  logic [IDX_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic [INC_WIDTH-1:0] rd_inc;

  assign sample = sc_q1 & ~sc_q2;
  assign tick = sample && pre == PW'(TICK_DIV - 1);
  assign t_next = {1'b0, t} + 1'b1;
  assign sl_eff = (step_len == '0) ? (DUR_WIDTH + 1)'(1) : {1'b0, step_len};
  assign step_end = state == PLAY && tick && t_next == sl_eff;
  assign last = bus.step_idx >= bus.num_steps;
  // the RAM address is the index being entered, so the read completes during LOAD
  assign rd_addr = (bus.start || (step_end && last)) ? '0 : bus.step_idx + 1'b1;
  assign rd_inc = rd_data[INC_LSB +: INC_WIDTH];
  assign rd_gl = rd_data[GL_LSB +: DUR_WIDTH];
  assign rd_sl = rd_data[SL_LSB +: DUR_WIDTH];

  note_sequencer_step_ram ram (
    .clk(clk),
    .wr_en(bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // two-stage capture of the sample clock level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q1 <= 1'b0;
      sc_q2 <= 1'b0;
    end else begin
      sc_q1 <= sample_clock;
      sc_q2 <= sc_q1;
    end
  end

  // prescaler and per-step tick count, both restarted by every step load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      t <= '0;
    end else if (state == LOAD) begin
      pre <= '0;
      t <= '0;
    end else if (state == PLAY && sample) begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) t <= t_next[DUR_WIDTH-1:0];
    end
  end

  // sequencer FSM with registered outputs; step end keeps the gate for legato
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus.gate <= 1'b0;
      bus.increment <= '0;
      bus.step_idx <= '0;
      bus.step_strobe <= 1'b0;
      bus.running <= 1'b0;
      gate_len <= '0;
      step_len <= '0;
    end else begin
      bus.step_strobe <= 1'b0;
      if (bus.stop) begin
        state <= IDLE;
        bus.gate <= 1'b0;
        bus.running <= 1'b0;
      end else if (bus.start) begin
        state <= LOAD;
        bus.step_idx <= '0;
        bus.gate <= 1'b0;
        bus.running <= 1'b1;
      end else if (state == LOAD) begin
        state <= PLAY;
        bus.increment <= rd_inc;
        gate_len <= rd_gl;
        step_len <= rd_sl;
        bus.gate <= rd_gl != '0 && rd_inc != '0;
        bus.step_strobe <= 1'b1;
      end else if (step_end) begin
        if (last && !bus.loop_en) begin
          state <= IDLE;
          bus.gate <= 1'b0;
          bus.running <= 1'b0;
        end else begin
          state <= LOAD;
          bus.step_idx <= rd_addr;
        end
      end else if (state == PLAY && tick && t_next == {1'b0, gate_len}) begin
        bus.gate <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: table vectors, corner sequences and random runs against a sample-count model
module tb_note_sequencer;
  import note_sequencer_pkg::*;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_clock = 1'b0;
  note_sequencer_if bus();

  note_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .rst(rst),
    .sample_clock(sample_clock),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (4) @(negedge clk);
    sample_clock = ~sample_clock;
  end

  int vectors = 0;
  int miscompares = 0;
  int pcount = 0;
  logic pulse = 1'b0;

  logic [WORD_W-1:0] mem [STEPS];
  int m_mode;
  int samples;
  logic m_s1, m_s2;
  logic [WORD_W-1:0] rd, cur;
  logic e_gate, e_strobe, e_run;
  logic [INC_WIDTH-1:0] e_inc;
  logic [IDX_W-1:0] e_idx;

  typedef struct {
    int inc;
    int gl;
    int sl;
    int eg;
    int er;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    samples = 0;
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    rd = '0;
    cur = '0;
    e_gate = 1'b0;
    e_strobe = 1'b0;
    e_run = 1'b0;
    e_inc = '0;
    e_idx = '0;
  endtask

  // model: 0 idle, 1 loading, 2 playing; time measured in samples since the step began
  task automatic model_edge();
    logic p;
    int gl, sl;
    p = m_s1 & ~m_s2;
    m_s2 = m_s1;
    m_s1 = sample_clock;
    e_strobe = 1'b0;
    if (bus.stop) begin
      m_mode = 0;
      e_gate = 1'b0;
      e_run = 1'b0;
    end else if (bus.start) begin
      m_mode = 1;
      e_idx = '0;
      e_gate = 1'b0;
      e_run = 1'b1;
      rd = mem[0];
    end else if (m_mode == 1) begin
      cur = rd;
      e_inc = cur[INC_LSB +: INC_WIDTH];
      e_gate = cur[GL_LSB +: DUR_WIDTH] != 0 && cur[INC_LSB +: INC_WIDTH] != 0;
      e_strobe = 1'b1;
      m_mode = 2;
      samples = 0;
    end else if (m_mode == 2 && p) begin
      samples++;
      gl = int'(cur[GL_LSB +: DUR_WIDTH]);
      sl = int'(cur[SL_LSB +: DUR_WIDTH]);
      if (sl == 0) sl = 1;
      if (samples == TD * sl) begin
        if (e_idx >= bus.num_steps) begin
          if (bus.loop_en) begin
            e_idx = '0;
            m_mode = 1;
            rd = mem[0];
          end else begin
            m_mode = 0;
            e_gate = 1'b0;
            e_run = 1'b0;
          end
        end else begin
          e_idx = e_idx + 1'b1;
          m_mode = 1;
          rd = mem[e_idx];
        end
      end else if (samples == TD * gl) begin
        e_gate = 1'b0;
      end
    end
    if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic cyc();
    if (pulse) pcount++;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    pulse = m_s1 & ~m_s2;
    check("outputs",
          64'({bus.gate, bus.increment, bus.step_idx, bus.step_strobe, bus.running}),
          64'({e_gate, e_inc, e_idx, e_strobe, e_run}));
  endtask

  task automatic wr(input int a, input logic [WORD_W-1:0] w);
    bus.wr_en = 1'b1;
    bus.wr_addr = IDX_W'(a);
    bus.wr_data = w;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic stop_pulse();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  function automatic logic [WORD_W-1:0] sw(input int inc, input int gl, input int sl);
    return step_word(INC_WIDTH'(inc), DUR_WIDTH'(gl), DUR_WIDTH'(sl));
  endfunction

  task automatic wait_strobe();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (bus.step_strobe) break;
    end
    check("strobe_seen", 64'(bus.step_strobe), 64'(1));
  endtask

  task automatic run_until_idle(output int gs, output int rs);
    bit seen;
    seen = 1'b0;
    gs = 0;
    rs = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (bus.step_strobe) seen = 1'b1;
      if (pulse && seen && bus.running) rs++;
      if (pulse && seen && bus.gate) gs++;
      if (!bus.running) break;
    end
    check("idle_reached", 64'(bus.running), 64'(0));
  endtask

  function automatic logic [WORD_W-1:0] rnd_word();
    int inc;
    inc = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, (1 << INC_WIDTH) - 1));
    return sw(inc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endfunction

  initial begin
    int g, r, last_pc, low, base, gh;
    tbl[0] = '{17582, 3, 5, 12, 20};
    tbl[1] = '{1000, 0, 3, 0, 12};
    tbl[2] = '{0, 2, 3, 0, 12};
    tbl[3] = '{500, 5, 2, 8, 8};
    tbl[4] = '{700, 1, 0, 4, 4};
    tbl[5] = '{800, 2, 1, 4, 4};
    tbl[6] = '{300, 1, 3, 4, 12};
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.num_steps = '0;
    bus.loop_en = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    for (int i = 0; i < STEPS; i++) mem[i] = '0;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;
    for (int i = 0; i < STEPS; i++) wr(i, '0);

    for (int i = 0; i < 7; i++) begin
      wr(0, sw(tbl[i].inc, tbl[i].gl, tbl[i].sl));
      bus.num_steps = '0;
      bus.loop_en = 1'b0;
      start_pulse();
      run_until_idle(g, r);
      check($sformatf("tbl%0d_gate_samples", i), 64'(g), 64'(tbl[i].eg));
      check($sformatf("tbl%0d_run_samples", i), 64'(r), 64'(tbl[i].er));
      check($sformatf("tbl%0d_inc_hold", i), 64'(bus.increment), 64'(tbl[i].inc));
    end

    wr(0, sw(1000, 2, 4));
    wr(1, sw(2000, 2, 4));
    bus.num_steps = 4'd1;
    bus.loop_en = 1'b1;
    start_pulse();
    last_pc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_strobe();
      check($sformatf("loop_idx%0d", k), 64'(bus.step_idx), 64'(k % 2));
      if (k > 0) check($sformatf("loop_len%0d", k), 64'(pcount - last_pc), 64'(16));
      last_pc = pcount;
    end
    wr(1, sw(3000, 2, 4));
    check("wr_keeps_current", 64'(bus.increment), 64'(2000));
    wait_strobe();
    wait_strobe();
    check("wr_new_idx", 64'(bus.step_idx), 64'(1));
    check("wr_new_inc", 64'(bus.increment), 64'(3000));
    stop_pulse();

    wr(0, sw(1000, 6, 4));
    wr(1, sw(0, 3, 3));
    bus.loop_en = 1'b0;
    start_pulse();
    wait_strobe();
    check("leg_gate_on", 64'(bus.gate), 64'(1));
    low = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (bus.step_strobe) break;
      if (!bus.gate) low++;
    end
    check("leg_no_drop", 64'(low), 64'(0));
    check("leg_rest_idx", 64'(bus.step_idx), 64'(1));
    check("leg_rest_gate", 64'(bus.gate), 64'(0));
    check("leg_rest_inc", 64'(bus.increment), 64'(0));
    run_until_idle(g, r);

    wr(0, sw(1000, 6, 8));
    bus.num_steps = '0;
    start_pulse();
    wait_strobe();
    base = pcount;
    for (int n = 0; n < 500 && pcount - base < 3; n++) cyc();
    stop_pulse();
    check("stop_running", 64'(bus.running), 64'(0));
    check("stop_gate", 64'(bus.gate), 64'(0));
    check("stop_inc_hold", 64'(bus.increment), 64'(1000));
    bus.start = 1'b1;
    bus.stop = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    check("start_stop_running", 64'(bus.running), 64'(0));
    repeat (10) cyc();
    check("start_stop_idle", 64'(bus.running), 64'(0));

    start_pulse();
    wait_strobe();
    repeat (20) cyc();
    check("pre_restart_gate", 64'(bus.gate), 64'(1));
    start_pulse();
    check("restart_gate_low", 64'(bus.gate), 64'(0));
    check("restart_running", 64'(bus.running), 64'(1));
    cyc();
    check("restart_gate_high", 64'(bus.gate), 64'(1));
    check("restart_strobe", 64'(bus.step_strobe), 64'(1));
    check("restart_idx", 64'(bus.step_idx), 64'(0));

    repeat (30) cyc();
    #2 rst = 1'b1;
    #1;
    check("rst_async", 64'({bus.gate, bus.increment, bus.step_idx, bus.step_strobe, bus.running}), 64'(0));
    repeat (3) cyc();
    rst = 1'b0;
    gh = 0;
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (bus.gate || bus.running) gh++;
    end
    check("rst_no_gate", 64'(gh), 64'(0));

    for (int it = 0; it < 8; it++) begin
      stop_pulse();
      for (int s = 0; s < 4; s++) wr(s, rnd_word());
      bus.num_steps = IDX_W'($urandom_range(0, 3));
      bus.loop_en = 1'($urandom_range(0, 1));
      start_pulse();
      for (int c = 0; c < 800; c++) begin
        int x;
        x = int'($urandom_range(0, 999));
        bus.start = (x < 3) || (!bus.running && x < 60);
        bus.stop = x >= 3 && x < 5;
        bus.wr_en = x >= 60 && x < 80;
        bus.wr_addr = IDX_W'($urandom_range(0, 3));
        bus.wr_data = rnd_word();
        if (x >= 80 && x < 83) bus.num_steps = IDX_W'($urandom_range(0, 3));
        cyc();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.wr_en = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
